dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Shares the single-port data DRAM between the processor datapath and a host loader port. The host loads operand matrices before a run and reads results back after it; the processor owns the memory exclusively while a run is in progress. Sits in the top level between the processor's `ar_out`/`bus_out`/`dm_en`/`dm_out` and the DRAM instance, and gates the processor start with a ready handshake.

## Interface
- `AW`, 16: address width.
- `DW`, 8: data width.
- `RD_LAT`, 1: DRAM read latency in cycles, from address presented to `mem_q` valid; legal range 1–3.

- `clock`  in  1  system clock (divided clock); all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `proc_req`  in  1  processor requests ownership; held high for the whole run.
- `proc_ready`  out  1  processor owns memory; it may start issuing accesses.
- `cpu_addr`  in  AW  processor address.
- `cpu_wdata`  in  DW  processor write data.
- `cpu_wren`  in  1  processor write enable.
- `cpu_rdata`  out  DW  read data to the processor: `mem_q`, passed through.
- `host_req`  in  1  host access request, one access per cycle.
- `host_we`  in  1  1 means write, 0 means read; qualified by `host_req`.
- `host_addr`  in  AW  host address.
- `host_wdata`  in  DW  host write data.
- `host_gnt`  out  1  the host access is accepted this cycle.
- `host_rvalid`  out  1  `host_rdata` is valid.
- `host_rdata`  out  DW  host read data.
- `mem_addr`  out  AW  to DRAM address.
- `mem_data`  out  DW  to DRAM data.
- `mem_wren`  out  1  to DRAM wren.
- `mem_q`  in  DW  from DRAM q.
- `owner`  out  2  current state encoding.
- `err`  out  1  sticky; set by an illegal processor write.

## Operation
States:
- HOST_OWN (reset state).
- DRAIN.
- CPU_OWN.
- GUARD.

HOST_OWN:
- The mux selects the host port.
- `host_gnt = host_req` (combinational).
- `mem_wren = host_req & host_we`.
- `proc_ready = 0`.
- If `proc_req` is high, go to DRAIN next cycle. `host_gnt` is 0 from the DRAIN cycle onward.

DRAIN:
- Lasts exactly RD_LAT cycles, tracked by a down-counter loaded with RD_LAT-1.
- `host_gnt = 0` and `mem_wren = 0`.
- The mux holds its host selection so that outstanding host reads complete.
- At the end of DRAIN: go to CPU_OWN if `proc_req` is still high, otherwise back to HOST_OWN.

CPU_OWN:
- The mux selects the processor port.
- `mem_wren = cpu_wren`.
- `proc_ready = 1`.
- `host_gnt = 0`; host requests stall. The host must hold `host_req` until it sees `host_gnt`.
- If `proc_req` falls, go to GUARD.

GUARD:
- One cycle.
- `mem_wren = 0`, `proc_ready = 0`, `host_gnt = 0`.
- Next state is HOST_OWN, even if `proc_req` has risen again. A new `proc_req` is then honoured from HOST_OWN.

Host read tagging:
- An RD_LAT-deep shift register carries `host_gnt & ~host_we`.
- `host_rvalid` is the shift register's output.
- `host_rdata = mem_q` while `host_rvalid` is high, and holds its last value otherwise.

Illegal processor writes:
- Condition: `cpu_wren` high in any state other than CPU_OWN.
- The write is suppressed (never reaches `mem_wren`).
- `err` is set and stays set until reset.

`owner` encoding: HOST_OWN=0, DRAIN=1, CPU_OWN=2, GUARD=3.

## Timing
- Reset values:
  - state HOST_OWN, so `owner = 0`.
  - `proc_ready`, `host_rvalid`, `err`, `mem_wren` all 0.
  - `host_rdata` = 0.
  - shift register and drain counter cleared.
- `host_gnt` and `mem_wren` are combinational from the registered state and the inputs. `owner`, `proc_ready`, `host_rvalid` and `host_rdata` are registered.
- From `proc_req` rising (sampled in HOST_OWN) to `proc_ready` high: RD_LAT+1 cycles.
- From `proc_req` falling to the first possible `host_gnt`: 2 cycles.
- Host read throughput: one read per cycle, with `host_rvalid` arriving RD_LAT cycles after `host_gnt`.
- A host request and a `proc_req` rise in the same HOST_OWN cycle: the host access is granted in that cycle, and ownership transfer begins the next cycle.
- `rst_n` low mid-run: the next edge forces HOST_OWN and drops `proc_ready`. Reads in flight in the shift register are discarded.

## Structure
- Package `dram_arb_pkg` holds:
  - the state encoding constants;
  - the default AW and DW values, shared with the top level.
- Natural sub-module: `rd_tag_pipe`, a parameterised RD_LAT-deep valid/ready-less shift register. It is reused for the host rvalid.
- Everything else is a single FSM plus a mux.

## Test plan
- Host write then read: write 0xA5 to 0x0010, then read 0x0010 → `host_gnt` high in both cycles; `host_rvalid` goes high RD_LAT cycles after the read with `host_rdata` = 0xA5; `mem_wren` high for exactly 1 cycle.
- Handover with RD_LAT=2: two back-to-back host reads, then `proc_req` rises → both `host_rvalid` pulses delivered; `owner` sequence 0,1,1,2; `proc_ready` high 3 cycles after `proc_req`.
- Run and return: processor writes 0x3C to 0x0020 in CPU_OWN, then `proc_req` drops while `host_req` is held high → one GUARD cycle with `host_gnt` = 0; host reads 0x3C.
- Illegal write: `cpu_wren` pulse while in HOST_OWN → `mem_wren` stays 0, `err` = 1 and remains set; a later host read of that address returns the old value.
- `proc_req` withdrawn during DRAIN → returns to HOST_OWN; `proc_ready` never asserts.
- `rst_n` low for 1 cycle in CPU_OWN → next cycle `owner` = 0, `proc_ready` = 0, `err` = 0, no spurious `host_rvalid`.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the data-DRAM arbiter: ownership state encoding and
// the default address/data widths used by the top level and its interface.
// Contents: own_state_t (HOST_OWN/DRAIN/CPU_OWN/GUARD), AW_DEF, DW_DEF.
package dram_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  // Encoding is visible on the 'owner' output, so the values are fixed.
  typedef enum logic [1:0] {
    HOST_OWN = 2'd0,
    DRAIN    = 2'd1,
    CPU_OWN  = 2'd2,
    GUARD    = 2'd3
  } own_state_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Host loader port of the data-DRAM arbiter, one access per cycle.
// master: host side drives req/we/addr/wdata and sees gnt/rvalid/rdata.
// slave:  arbiter side, the mirror image.
interface dram_arbiter_if
  import dram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata
  );

endinterface

// File: rtl/dram_arbiter_rd_tag_pipe.sv
// Fixed-depth single-bit shift register tagging reads in flight to the DRAM.
// Latency: DEPTH cycles from din to dout. No backpressure; advances every cycle.
// Ports: clock, rst_n (sync, active-low, clears all stages), din, dout.
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data DRAM between the processor and the host loader.
// Latency: proc_req to proc_ready RD_LAT+1 cycles; host read data RD_LAT cycles after host_gnt.
// Backpressure: host_gnt held low outside HOST_OWN; the host keeps host_req up until granted.
// Ports: clock/rst_n; proc_req/proc_ready handshake; cpu_addr/cpu_wdata/cpu_wren/cpu_rdata
// processor port; host (dram_arbiter_if.slave) loader port; mem_addr/mem_data/mem_wren/mem_q
// to the DRAM; owner (state) and err (sticky illegal processor write) status.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          proc_req,
  output logic          proc_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_wren,
  output logic [DW-1:0] cpu_rdata,
  dram_arbiter_if.slave host,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic [1:0]    owner,
  output logic          err
);

  // Drain down-counter start value: DRAIN lasts RD_LAT cycles.
  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

  own_state_t    state, state_nxt;
  logic [1:0]    drain_cnt, drain_cnt_nxt;
  logic          sel_cpu;
  logic          gnt;
  logic          wren;
  logic [DW-1:0] rdata_hold;

  // ---------------------------------------------------------------------------
  // State register and registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= HOST_OWN;
      drain_cnt  <= '0;
      proc_ready <= 1'b0;
      err        <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= drain_cnt_nxt;
      // Registered copy of "next state is CPU_OWN" so it lines up with owner.
      proc_ready <= (state_nxt == CPU_OWN);
      // A processor write outside its ownership window is dropped and flagged.
      if (cpu_wren && (state != CPU_OWN)) begin
        err <= 1'b1;
      end
      if (host.host_rvalid) begin
        rdata_hold <= mem_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and combinational grant / write-enable
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    sel_cpu       = 1'b0;
    gnt           = 1'b0;
    wren          = 1'b0;
    case (state)
      HOST_OWN: begin
        // A host access in the same cycle as proc_req still gets granted.
        gnt  = host.host_req;
        wren = host.host_req & host.host_we;
        if (proc_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_INIT;
        end
      end
      DRAIN: begin
        // Mux stays on the host so reads already issued return cleanly.
        if (drain_cnt == 2'd0) begin
          state_nxt = proc_req ? CPU_OWN : HOST_OWN;
        end else begin
          drain_cnt_nxt = drain_cnt - 2'd1;
        end
      end
      CPU_OWN: begin
        sel_cpu = 1'b1;
        wren    = cpu_wren;
        if (!proc_req) begin
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        // Always return to the host for at least one cycle.
        state_nxt = HOST_OWN;
      end
      default: begin
        state_nxt = HOST_OWN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory mux and host read return
  // ---------------------------------------------------------------------------
  assign mem_addr  = sel_cpu ? cpu_addr  : host.host_addr;
  assign mem_data  = sel_cpu ? cpu_wdata : host.host_wdata;
  assign mem_wren  = wren;
  assign cpu_rdata = mem_q;
  assign owner     = state;

  assign host.host_gnt = gnt;

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag (
    .clock (clock),
    .rst_n (rst_n),
    .din   (gnt & ~host.host_we),
    .dout  (host.host_rvalid)
  );

  // mem_q is only valid in the tagged cycle, so it is forwarded then and the
  // last returned value is held between reads.
  assign host.host_rdata = host.host_rvalid ? mem_q : rdata_hold;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomised and directed self-checking bench for dram_arbiter.
// A behavioural DRAM with RD_LAT-cycle read latency sits behind the arbiter;
// a queue-based reference model predicts every output each cycle.
module tb_dram_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          proc_req;
  logic          proc_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wren;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic [1:0]    owner;
  logic          err;

  dram_arbiter_if #(.AW(AW), .DW(DW)) host_bus ();

  dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .proc_req   (proc_req),
    .proc_ready (proc_ready),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wren   (cpu_wren),
    .cpu_rdata  (cpu_rdata),
    .host       (host_bus),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .owner      (owner),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Behavioural DRAM: address sampled at the edge, q appears RD_LAT cycles later.
  logic [DW-1:0] dram  [0:65535];
  logic [DW-1:0] qpipe [0:RD_LAT-1];
  assign mem_q = qpipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < 65536; i++) dram[i] = '0;
    for (int i = 0; i < RD_LAT; i++) qpipe[i] = '0;
    forever begin
      @(posedge clock);
      qpipe[0] <= dram[mem_addr];
      for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
      if (mem_wren) dram[mem_addr] <= mem_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [7:0]  data;
  } rd_t;

  rd_t        m_rq[$];
  logic [7:0] shadow [0:65535];
  int         m_own;    // 0 host, 1 draining, 2 processor, 3 guard
  int         m_left;   // drain cycles still to run
  int         cyc;
  bit         m_ready;
  bit         m_err;
  logic [7:0] m_rdata;

  function automatic void model_reset();
    m_own   = 0;
    m_left  = 0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
    m_rq.delete();
  endfunction

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic cycle(input bit pr, input bit hr, input bit hw, input logic [15:0] ha,
                       input logic [7:0] hd, input bit cw, input logic [15:0] ca,
                       input logic [7:0] cd);
    bit          e_gnt, e_wren, e_rv;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    int          nxt;
    @(negedge clock);
    rst_n                = 1'b1;
    proc_req             = pr;
    host_bus.host_req    = hr;
    host_bus.host_we     = hw;
    host_bus.host_addr   = ha;
    host_bus.host_wdata  = hd;
    cpu_wren             = cw;
    cpu_addr             = ca;
    cpu_wdata            = cd;
    #1;
    e_gnt  = (m_own == 0) && hr;
    e_wren = (m_own == 0) ? (hr && hw) : ((m_own == 2) ? cw : 1'b0);
    e_rv   = (m_rq.size() > 0) && (m_rq[0].due == cyc);
    check("owner",       32'(owner),                32'(m_own));
    check("proc_ready",  32'(proc_ready),           32'(m_ready));
    check("err",         32'(err),                  32'(m_err));
    check("host_gnt",    32'(host_bus.host_gnt),    32'(e_gnt));
    check("mem_wren",    32'(mem_wren),             32'(e_wren));
    check("host_rvalid", 32'(host_bus.host_rvalid), 32'(e_rv));
    check("cpu_rdata",   32'(cpu_rdata),            32'(mem_q));
    if (e_rv) begin
      m_rdata = m_rq[0].data;
      void'(m_rq.pop_front());
    end
    check("host_rdata", 32'(host_bus.host_rdata), 32'(m_rdata));
    if (e_wren) begin
      e_addr = (m_own == 2) ? ca : ha;
      e_data = (m_own == 2) ? cd : hd;
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_data", 32'(mem_data), 32'(e_data));
      shadow[e_addr] = e_data;
    end
    if (e_gnt && !hw) m_rq.push_back(rd_t'{due: cyc + RD_LAT, data: shadow[ha]});
    if (cw && m_own != 2) m_err = 1'b1;
    case (m_own)
      0: begin
        nxt = pr ? 1 : 0;
        if (pr) m_left = RD_LAT;
      end
      1: begin
        m_left--;
        nxt = (m_left > 0) ? 1 : (pr ? 2 : 0);
      end
      2:       nxt = pr ? 2 : 3;
      default: nxt = 0;
    endcase
    m_own   = nxt;
    m_ready = (nxt == 2);
    cyc++;
  endtask

  task automatic idle(input bit pr);
    cycle(pr, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n             = 1'b0;
    proc_req          = 1'b0;
    host_bus.host_req = 1'b0;
    cpu_wren          = 1'b0;
    model_reset();
    cyc++;
  endtask

  bit          rp;
  bit          rcw;
  logic [15:0] raddr;

  initial begin
    rst_n               = 1'b0;
    proc_req            = 1'b0;
    host_bus.host_req   = 1'b0;
    host_bus.host_we    = 1'b0;
    host_bus.host_addr  = '0;
    host_bus.host_wdata = '0;
    cpu_wren            = 1'b0;
    cpu_addr            = '0;
    cpu_wdata           = '0;
    cyc                 = 0;
    for (int i = 0; i < 65536; i++) shadow[i] = '0;
    do_reset();
    do_reset();

    // Reset state
    idle(1'b0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_ready", 32'(proc_ready), 32'd0);
    check("rst_rvalid", 32'(host_bus.host_rvalid), 32'd0);
    check("rst_rdata", 32'(host_bus.host_rdata), 32'd0);

    // Host write then read back
    cycle(1'b0, 1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 16'h0, 8'h0);
    check("wr_gnt", 32'(host_bus.host_gnt), 32'd1);
    check("wr_wren", 32'(mem_wren), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0, 8'h0);
    check("rd_gnt", 32'(host_bus.host_gnt), 32'd1);
    check("rd_wren", 32'(mem_wren), 32'd0);
    idle(1'b0);
    check("rd_rv_early", 32'(host_bus.host_rvalid), 32'd0);
    idle(1'b0);
    check("rd_rv", 32'(host_bus.host_rvalid), 32'd1);
    check("rd_data", 32'(host_bus.host_rdata), 32'hA5);

    // Handover with two reads in flight
    cycle(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0, 8'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0011, 8'h00, 1'b0, 16'h0, 8'h0);
    idle(1'b1);
    check("ho_own0", 32'(owner), 32'd0);
    check("ho_rv0", 32'(host_bus.host_rvalid), 32'd1);
    check("ho_rd0", 32'(host_bus.host_rdata), 32'hA5);
    idle(1'b1);
    check("ho_own1", 32'(owner), 32'd1);
    check("ho_rv1", 32'(host_bus.host_rvalid), 32'd1);
    idle(1'b1);
    check("ho_own2", 32'(owner), 32'd1);
    check("ho_rdy2", 32'(proc_ready), 32'd0);
    idle(1'b1);
    check("ho_own3", 32'(owner), 32'd2);
    check("ho_rdy3", 32'(proc_ready), 32'd1);

    // Run and return: processor write, then host read after GUARD
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0020, 8'h3C);
    check("cpu_wren", 32'(mem_wren), 32'd1);
    check("cpu_addr", 32'(mem_addr), 32'h20);
    cycle(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 16'h0, 8'h0);
    check("ret_gnt_cpu", 32'(host_bus.host_gnt), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 16'h0, 8'h0);
    check("ret_own_guard", 32'(owner), 32'd3);
    check("ret_gnt_guard", 32'(host_bus.host_gnt), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 16'h0, 8'h0);
    check("ret_gnt_host", 32'(host_bus.host_gnt), 32'd1);
    idle(1'b0);
    idle(1'b0);
    check("ret_rdata", 32'(host_bus.host_rdata), 32'h3C);

    // Illegal processor write in HOST_OWN
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0010, 8'hFF);
    check("ill_wren", 32'(mem_wren), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0, 8'h0);
    check("ill_err", 32'(err), 32'd1);
    idle(1'b0);
    idle(1'b0);
    check("ill_rdata", 32'(host_bus.host_rdata), 32'hA5);
    check("ill_err_sticky", 32'(err), 32'd1);

    // proc_req withdrawn during DRAIN
    idle(1'b1);
    idle(1'b0);
    check("wd_own1", 32'(owner), 32'd1);
    idle(1'b0);
    check("wd_rdy", 32'(proc_ready), 32'd0);
    idle(1'b0);
    check("wd_own0", 32'(owner), 32'd0);
    check("wd_rdy_end", 32'(proc_ready), 32'd0);

    // Reset while the processor owns memory
    cycle(1'b1, 1'b1, 1'b0, 16'h0011, 8'h00, 1'b0, 16'h0, 8'h0);
    check("same_cyc_gnt", 32'(host_bus.host_gnt), 32'd1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check("rst_run_own", 32'(owner), 32'd2);
    do_reset();
    idle(1'b0);
    check("rst_mid_own", 32'(owner), 32'd0);
    check("rst_mid_rdy", 32'(proc_ready), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_rv", 32'(host_bus.host_rvalid), 32'd0);

    // Reads in flight are discarded by reset
    cycle(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0, 8'h0);
    do_reset();
    idle(1'b0);
    check("rst_drop_rv", 32'(host_bus.host_rvalid), 32'd0);
    idle(1'b0);

    // Randomised traffic
    rp = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rp = ~rp;
      raddr = 16'($urandom_range(0, 15));
      rcw   = (m_own == 2) && ($urandom_range(0, 1) == 1);
      cycle(rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr,
            8'($urandom), rcw, 16'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
